// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers used by the counter (encode side) and the matching decoder.
// Functions work on a fixed maximum width; callers zero-extend and truncate to their own width.
package gray_counter_pkg;

  localparam int unsigned CODE_MAX_W = 32;

  function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper zero bits leave the prefix XOR untouched, so truncation yields the narrow result.
  function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] g);
    logic [CODE_MAX_W-1:0] b;
    b[CODE_MAX_W-1] = g[CODE_MAX_W-1];
    for (int i = CODE_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_bin_to_gray.sv
// Combinational WIDTH-bit binary-to-Gray encoder wrapping the package function.
module bin_to_gray
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray(CODE_MAX_W'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered, always-coherent Gray code and wrap/step pulses.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             step
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(CODE_MAX_W'(RST_BIN)));

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             step_q, step_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    step_d = 1'b0;
    if (clr) begin
      bin_d = RST_BIN;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      step_d = 1'b1;
      if (up_dn) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = (bin_q == '1);
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = (bin_q == '0);
      end
    end
  end

  // Gray is encoded from the next binary value so both registers update on the same edge.
  bin_to_gray #(.WIDTH(WIDTH)) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      step_q <= step_d;
    end
  end

  assign binary = bin_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;
  assign step   = step_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: stimulus pushes model expectations, a monitor pops and compares.
module tb_gray_counter;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] binary, gray;
  logic         wrap, step;

  gray_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
    .en(en), .up_dn(up_dn), .binary(binary), .gray(gray), .wrap(wrap), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    b;
    int    g;
    bit    w;
    bit    s;
    string tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   model_b = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b / 2)) % MOD;
  endfunction

  // Independent decoder: bit i of binary is the parity of gray bits i and above.
  function automatic int decode(input logic [W-1:0] g);
    int r = 0;
    for (int i = 0; i < W; i++) begin
      if ($countones(g >> i) % 2 == 1) r += (1 << i);
    end
    return r;
  endfunction

  task automatic cycle(input bit c, input bit l, input int lb, input bit e, input bit u,
                       input string tag);
    exp_t x;
    int   nb;
    @(negedge clk);
    clr = c; load = l; load_bin = W'(lb); en = e; up_dn = u;
    x.w = 0; x.s = 0;
    if (c)      nb = 0;
    else if (l) nb = lb % MOD;
    else if (e) begin
      x.s = 1;
      if (u) begin x.w = (model_b == MOD - 1); nb = (model_b + 1) % MOD; end
      else   begin x.w = (model_b == 0);       nb = (model_b + MOD - 1) % MOD; end
    end else nb = model_b;
    model_b = nb;
    x.b = nb; x.g = to_gray(nb); x.tag = tag;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    logic [W-1:0] prev_g;
    forever begin
      @(negedge clk);
      prev_g = gray;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check({x.tag, ".binary"}, int'(binary), x.b);
        check({x.tag, ".gray"}, int'(gray), x.g);
        check({x.tag, ".wrap"}, int'(wrap), int'(x.w));
        check({x.tag, ".step"}, int'(step), int'(x.s));
        check({x.tag, ".decode"}, decode(gray), x.b);
        if (x.s) check({x.tag, ".onebit"}, $countones(gray ^ prev_g), 1);
      end
    end
  end

  task automatic check_reset_now(input string tag);
    check({tag, ".binary"}, int'(binary), 0);
    check({tag, ".gray"}, int'(gray), 0);
    check({tag, ".wrap"}, int'(wrap), 0);
    check({tag, ".step"}, int'(step), 0);
  endtask

  initial begin : stim
    #2;
    check_reset_now("rst_init");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_b = 0;

    repeat (3) cycle(0, 0, 0, 0, 1, "hold");
    for (int i = 0; i < MOD; i++) cycle(0, 0, 0, 1, 1, "up_full");

    cycle(1, 0, 0, 0, 0, "clr");
    cycle(0, 0, 0, 1, 0, "down_wrap");
    cycle(0, 0, 0, 1, 0, "down_next");

    cycle(0, 1, 5, 1, 1, "load_pri");
    cycle(0, 0, 0, 1, 1, "load_up");

    cycle(1, 1, 10, 1, 1, "clr_pri");
    cycle(0, 1, 10, 0, 0, "load_a");

    cycle(1, 0, 0, 0, 0, "clr2");
    repeat (7) cycle(0, 0, 0, 1, 1, "up7");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_now("rst_mid");
    model_b = 0;
    #1 rst_n = 1'b1;
    cycle(0, 0, 0, 1, 1, "after_rst");

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, MOD - 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected under 200000", $time);
    $fatal(1);
  end

endmodule
